fwd_scoreboard: RTL and testbench

- Parametrised successor to the two-port forwarding unit. Tracks destination tags of in-flight instructions across DEPTH post-EX pipeline stages in a registered shift structure.
- Produces per-source forward selects for NUM_SRC operands of the EX-stage instruction, and a load-use stall for a configurable load latency.
- Sits beside the ID/EX-EX/MEM-MEM/WB registers. The datapath uses fwd_sel to steer its operand muxes.

---
 rtl/fwd_scoreboard_if.sv | 40 ++++
 rtl/fwd_scoreboard.sv | 121 ++++++++++++
 tb/tb_fwd_scoreboard.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/fwd_scoreboard_if.sv
// Bundle between the EX stage and the forwarding scoreboard.
// Statistics outputs exist only when FWD_SCOREBOARD_STATS_EN is defined.
interface fwd_scoreboard_if #(
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 2,
  parameter int REG_AW  = 5
);
  localparam int SELW = $clog2(DEPTH + 1);

  logic                      ex_valid;
  logic                      ex_wen;
  logic                      ex_load;
  logic [REG_AW-1:0]         ex_rd;
  logic [NUM_SRC*REG_AW-1:0] ex_rs;
  logic                      stall_in;
  logic                      flush;
  logic [NUM_SRC*SELW-1:0]   fwd_sel;
  logic [DEPTH-1:0]          fwd_stage_wen;
  logic                      stall_out;
`ifdef FWD_SCOREBOARD_STATS_EN
  logic [31:0]               stat_fwd_cnt;
  logic [31:0]               stat_stall_cnt;
`endif

  modport master (
`ifdef FWD_SCOREBOARD_STATS_EN
    input  stat_fwd_cnt, stat_stall_cnt,
`endif
    output ex_valid, ex_wen, ex_load, ex_rd, ex_rs, stall_in, flush,
    input  fwd_sel, fwd_stage_wen, stall_out
  );

  modport slave (
`ifdef FWD_SCOREBOARD_STATS_EN
    output stat_fwd_cnt, stat_stall_cnt,
`endif
    input  ex_valid, ex_wen, ex_load, ex_rd, ex_rs, stall_in, flush,
    output fwd_sel, fwd_stage_wen, stall_out
  );
endinterface

// File: rtl/fwd_scoreboard.sv
// Destination-tag scoreboard over DEPTH post-EX stages: operand forward selects and load-use stall.
// Optional counters enabled by defining FWD_SCOREBOARD_STATS_EN.
module fwd_scoreboard #(
  parameter int NUM_SRC  = 2,
  parameter int DEPTH    = 2,
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic             CLK,
  input  logic             nRST,
  fwd_scoreboard_if.slave  bus
);
  localparam int SELW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]                r_valid;
  logic [DEPTH-1:0]                r_wen;
  logic [DEPTH-1:0]                r_load;
  logic [DEPTH-1:0][REG_AW-1:0]    r_rd;

  logic [DEPTH-1:0]                w_live;
  logic [NUM_SRC-1:0][DEPTH-1:0]   w_match;
  logic [NUM_SRC-1:0][SELW-1:0]    w_sel;
  logic [NUM_SRC-1:0]              w_ld_hit;
  logic                            w_stall;

  // Live entries and per-source tag matches
  always_comb begin
    w_live  = {DEPTH{1'b0}};
    w_match = {(NUM_SRC*DEPTH){1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      w_live[k] = r_valid[k] & r_wen[k] & (r_rd[k] != {REG_AW{1'b0}});
    end
    for (int j = 0; j < NUM_SRC; j++) begin
      for (int k = 0; k < DEPTH; k++) begin
        w_match[j][k] = w_live[k] & (r_rd[k] == bus.ex_rs[j*REG_AW +: REG_AW]);
      end
    end
  end

  // Priority select: walk oldest to youngest so the youngest match is left standing
  always_comb begin
    w_sel    = {(NUM_SRC*SELW){1'b0}};
    w_ld_hit = {NUM_SRC{1'b0}};
    for (int j = 0; j < NUM_SRC; j++) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        w_sel[j]    = w_match[j][k] ? SELW'(k + 1) : w_sel[j];
        w_ld_hit[j] = w_match[j][k] ? (r_load[k] & (k < LOAD_LAT)) : w_ld_hit[j];
      end
    end
    w_stall = bus.ex_valid & (|w_ld_hit);
  end

  assign bus.fwd_sel       = w_sel;
  assign bus.fwd_stage_wen = w_live;
  assign bus.stall_out     = w_stall;

  // Stage shift register: freeze beats flush/stall, which both inject a bubble
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_valid <= {DEPTH{1'b0}};
      r_wen   <= {DEPTH{1'b0}};
      r_load  <= {DEPTH{1'b0}};
      r_rd    <= {(DEPTH*REG_AW){1'b0}};
    end else if (bus.stall_in) begin
      r_valid <= r_valid;
      r_wen   <= r_wen;
      r_load  <= r_load;
      r_rd    <= r_rd;
    end else begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        r_valid[k] <= r_valid[k-1];
        r_wen[k]   <= r_wen[k-1];
        r_load[k]  <= r_load[k-1];
        r_rd[k]    <= r_rd[k-1];
      end
      if (bus.flush || w_stall) begin
        r_valid[0] <= 1'b0;
        r_wen[0]   <= 1'b0;
        r_load[0]  <= 1'b0;
        r_rd[0]    <= {REG_AW{1'b0}};
      end else begin
        r_valid[0] <= bus.ex_valid;
        r_wen[0]   <= bus.ex_wen;
        r_load[0]  <= bus.ex_load;
        r_rd[0]    <= bus.ex_rd;
      end
    end
  end

`ifdef FWD_SCOREBOARD_STATS_EN
  logic [31:0] r_fwd_cnt;
  logic [31:0] r_stall_cnt;
  logic        w_fwd_evt;
  logic        w_stall_evt;

  assign w_fwd_evt   = ~bus.stall_in & bus.ex_valid & ~w_stall & (|w_sel);
  assign w_stall_evt = ~bus.stall_in & w_stall;

  // Saturating event counters
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_fwd_cnt   <= 32'd0;
      r_stall_cnt <= 32'd0;
    end else begin
      if (w_fwd_evt && (r_fwd_cnt != 32'hFFFF_FFFF)) begin
        r_fwd_cnt <= r_fwd_cnt + 32'd1;
      end else begin
        r_fwd_cnt <= r_fwd_cnt;
      end
      if (w_stall_evt && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
    end
  end

  assign bus.stat_fwd_cnt   = r_fwd_cnt;
  assign bus.stat_stall_cnt = r_stall_cnt;
`endif
endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed table-driven bench for fwd_scoreboard (NUM_SRC=2, DEPTH=2, LOAD_LAT=1).
module tb_fwd_scoreboard;
  typedef struct {
    logic       v;
    logic       w;
    logic       l;
    logic [4:0] rd;
    logic [4:0] rs0;
    logic [4:0] rs1;
    logic       si;
    logic       fl;
    logic [1:0] e_sel0;
    logic [1:0] e_sel1;
    logic       e_stall;
    logic [1:0] e_swen;
  } vec_t;

  logic CLK;
  logic nRST;
  int   checks;
  int   errors;
  vec_t tbl[$];
  int   exp_fwd;
  int   exp_stl;

  fwd_scoreboard_if #(.NUM_SRC(2), .DEPTH(2), .REG_AW(5)) bus ();

  fwd_scoreboard #(.NUM_SRC(2), .DEPTH(2), .REG_AW(5), .LOAD_LAT(1)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic void chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic void add(logic v, logic w, logic l, logic [4:0] rd, logic [4:0] rs0,
                              logic [4:0] rs1, logic si, logic fl, logic [1:0] s0,
                              logic [1:0] s1, logic st, logic [1:0] sw);
    vec_t t;
    t = '{v, w, l, rd, rs0, rs1, si, fl, s0, s1, st, sw};
    tbl.push_back(t);
  endfunction

  task automatic apply(vec_t t, string tag);
    @(negedge CLK);
    bus.ex_valid = t.v;
    bus.ex_wen   = t.w;
    bus.ex_load  = t.l;
    bus.ex_rd    = t.rd;
    bus.ex_rs    = {t.rs1, t.rs0};
    bus.stall_in = t.si;
    bus.flush    = t.fl;
    #1;
    chk({tag, "_sel0"},  bus.fwd_sel[1:0],   t.e_sel0);
    chk({tag, "_sel1"},  bus.fwd_sel[3:2],   t.e_sel1);
    chk({tag, "_stall"}, bus.stall_out,      t.e_stall);
    chk({tag, "_swen"},  bus.fwd_stage_wen,  t.e_swen);
  endtask

  initial begin
    checks = 0; errors = 0; exp_fwd = 0; exp_stl = 0;
    nRST = 1'b0;
    bus.ex_valid = 1'b0; bus.ex_wen = 1'b0; bus.ex_load = 1'b0;
    bus.ex_rd = 5'd0; bus.ex_rs = 10'd0; bus.stall_in = 1'b0; bus.flush = 1'b0;

    //    v     w     l     rd     rs0    rs1    si    fl    sel0  sel1  stl   swen
    add(1'b1, 1'b1, 1'b0, 5'd3,  5'd1,  5'd2,  1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'b00); // 0 add r3
    add(1'b1, 1'b0, 1'b0, 5'd0,  5'd3,  5'd4,  1'b0, 1'b0, 2'd1, 2'd0, 1'b0, 2'b01); // 1 back-to-back
    add(1'b1, 1'b1, 1'b0, 5'd5,  5'd3,  5'd0,  1'b0, 1'b0, 2'd2, 2'd0, 1'b0, 2'b10); // 2 r3 at stage1
    add(1'b1, 1'b1, 1'b0, 5'd5,  5'd0,  5'd5,  1'b0, 1'b0, 2'd0, 2'd1, 1'b0, 2'b01); // 3
    add(1'b1, 1'b0, 1'b0, 5'd0,  5'd0,  5'd5,  1'b0, 1'b0, 2'd0, 2'd1, 1'b0, 2'b11); // 4 youngest wins
    add(1'b1, 1'b0, 1'b0, 5'd0,  5'd0,  5'd5,  1'b0, 1'b0, 2'd0, 2'd2, 1'b0, 2'b10); // 5
    add(1'b1, 1'b1, 1'b1, 5'd7,  5'd0,  5'd0,  1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'b00); // 6 lw r7
    add(1'b1, 1'b0, 1'b0, 5'd0,  5'd7,  5'd0,  1'b0, 1'b0, 2'd1, 2'd0, 1'b1, 2'b01); // 7 load-use
    add(1'b1, 1'b0, 1'b0, 5'd0,  5'd7,  5'd0,  1'b0, 1'b0, 2'd2, 2'd0, 1'b0, 2'b10); // 8 resolved
    add(1'b1, 1'b1, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'b00); // 9 write r0
    add(1'b1, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'b00); // 10
    add(1'b1, 1'b1, 1'b1, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'b00); // 11 load r0
    add(1'b1, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'b00); // 12 no stall
    add(1'b1, 1'b1, 1'b1, 5'd8,  5'd0,  5'd0,  1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'b00); // 13 lw r8
    add(1'b0, 1'b0, 1'b0, 5'd0,  5'd8,  5'd8,  1'b0, 1'b0, 2'd1, 2'd1, 1'b0, 2'b01); // 14 invalid EX
    add(1'b1, 1'b0, 1'b0, 5'd0,  5'd8,  5'd0,  1'b0, 1'b0, 2'd2, 2'd0, 1'b0, 2'b10); // 15
    add(1'b1, 1'b1, 1'b0, 5'd9,  5'd0,  5'd0,  1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 2'b00); // 16 flush r9
    add(1'b1, 1'b0, 1'b0, 5'd0,  5'd9,  5'd9,  1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'b00); // 17
    add(1'b1, 1'b0, 1'b0, 5'd0,  5'd9,  5'd9,  1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'b00); // 18
    add(1'b1, 1'b1, 1'b0, 5'd10, 5'd0,  5'd0,  1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'b00); // 19
    add(1'b1, 1'b1, 1'b0, 5'd11, 5'd10, 5'd0,  1'b0, 1'b0, 2'd1, 2'd0, 1'b0, 2'b01); // 20
    add(1'b1, 1'b1, 1'b0, 5'd12, 5'd10, 5'd11, 1'b1, 1'b0, 2'd2, 2'd1, 1'b0, 2'b11); // 21 freeze
    add(1'b1, 1'b1, 1'b0, 5'd12, 5'd10, 5'd11, 1'b1, 1'b1, 2'd2, 2'd1, 1'b0, 2'b11); // 22 freeze+flush
    add(1'b1, 1'b1, 1'b0, 5'd12, 5'd10, 5'd11, 1'b1, 1'b0, 2'd2, 2'd1, 1'b0, 2'b11); // 23
    add(1'b1, 1'b0, 1'b0, 5'd0,  5'd10, 5'd11, 1'b0, 1'b0, 2'd2, 2'd1, 1'b0, 2'b11); // 24 unfrozen
    add(1'b1, 1'b0, 1'b0, 5'd0,  5'd10, 5'd11, 1'b0, 1'b0, 2'd0, 2'd2, 1'b0, 2'b10); // 25
    add(1'b1, 1'b1, 1'b1, 5'd13, 5'd0,  5'd0,  1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'b00); // 26 lw r13
    add(1'b1, 1'b0, 1'b0, 5'd0,  5'd13, 5'd0,  1'b1, 1'b0, 2'd1, 2'd0, 1'b1, 2'b01); // 27 stall+freeze
    add(1'b1, 1'b0, 1'b0, 5'd0,  5'd13, 5'd0,  1'b1, 1'b0, 2'd1, 2'd0, 1'b1, 2'b01); // 28
    add(1'b1, 1'b0, 1'b0, 5'd0,  5'd13, 5'd0,  1'b0, 1'b0, 2'd1, 2'd0, 1'b1, 2'b01); // 29
    add(1'b1, 1'b0, 1'b0, 5'd0,  5'd13, 5'd0,  1'b0, 1'b0, 2'd2, 2'd0, 1'b0, 2'b10); // 30

    // Reset state with non-zero sources still presented
    repeat (2) @(negedge CLK);
    bus.ex_valid = 1'b1;
    bus.ex_rs = {5'd4, 5'd3};
    #1;
    chk("rst_sel",   bus.fwd_sel,       0);
    chk("rst_stall", bus.stall_out,     0);
    chk("rst_swen",  bus.fwd_stage_wen, 0);
`ifdef FWD_SCOREBOARD_STATS_EN
    chk("rst_fcnt",  bus.stat_fwd_cnt,   0);
    chk("rst_scnt",  bus.stat_stall_cnt, 0);
`endif
    nRST = 1'b1;

    foreach (tbl[i]) begin
      apply(tbl[i], $sformatf("v%0d", i));
      if (!tbl[i].si && tbl[i].e_stall) exp_stl++;
      if (!tbl[i].si && tbl[i].v && !tbl[i].e_stall && (tbl[i].e_sel0 != 2'd0 || tbl[i].e_sel1 != 2'd0))
        exp_fwd++;
    end

`ifdef FWD_SCOREBOARD_STATS_EN
    @(negedge CLK);
    #1;
    chk("stat_fwd",   bus.stat_fwd_cnt,   exp_fwd);
    chk("stat_stall", bus.stat_stall_cnt, exp_stl);
`endif

    // Async reset while a load-use stall is active
    begin
      vec_t t;
      t = '{1'b1, 1'b1, 1'b1, 5'd14, 5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'b00};
      apply(t, "ar_lw");
      t = '{1'b1, 1'b0, 1'b0, 5'd0, 5'd14, 5'd0, 1'b0, 1'b0, 2'd1, 2'd0, 1'b1, 2'b01};
      apply(t, "ar_use");
    end
    #2 nRST = 1'b0;
    #1;
    chk("ar_stall", bus.stall_out,     0);
    chk("ar_sel",   bus.fwd_sel,       0);
    chk("ar_swen",  bus.fwd_stage_wen, 0);
`ifdef FWD_SCOREBOARD_STATS_EN
    chk("ar_fcnt",  bus.stat_fwd_cnt,   0);
    chk("ar_scnt",  bus.stat_stall_cnt, 0);
`endif
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    #1;
    chk("post_sel",   bus.fwd_sel,   0);
    chk("post_stall", bus.stall_out, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
